// File: rtl/sram_1r1w_bwe_clr_pkg.sv
// ============================================================================
//  Package     : rfPhoenixPkg
//  Description : Shared types and lane-parity helper for sram_1r1w_bwe_clr.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rfPhoenixPkg;

    typedef enum logic {SRAM_CLR, SRAM_RUN} sram_init_state_t;

    localparam int SRAM_MAX_WID = 1024;
    localparam int SRAM_MAX_NB  = 1024;

    // Even parity per BWID-bit lane; callers truncate the result to their lane count.
    function automatic logic [SRAM_MAX_NB-1:0] lane_parity(
        input logic [SRAM_MAX_WID-1:0] d,
        input int                      wid,
        input int                      bwid
    );
        logic [SRAM_MAX_NB-1:0] p;
        p = '0;
        for (int b = 0; b < SRAM_MAX_WID; b++) begin
            if (b < wid) p[10'(b / bwid)] ^= d[b[9:0]];
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_1r1w_bwe_clr_if.sv
// ============================================================================
//  Interface   : sram_1r1w_bwe_clr_if
//  Description : Write/read port bundle of the 1R1W byte-enable SRAM.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sram_1r1w_bwe_clr_if #(
    parameter int WID = 257,
    parameter int NB  = 1,
    parameter int AW  = 10
);
    logic           rdy;
    logic           wr;
    logic [NB-1:0]  wsel;
    logic [AW-1:0]  wadr;
    logic [WID-1:0] i;
    logic           rd;
    logic [AW-1:0]  radr;
    logic [WID-1:0] o;
    logic           ov;
    logic           perr;
    logic           perr_inj;

    modport master (
        input  rdy, o, ov, perr,
        output wr, wsel, wadr, i, rd, radr, perr_inj
    );

    modport slave (
        output rdy, o, ov, perr,
        input  wr, wsel, wadr, i, rd, radr, perr_inj
    );
endinterface

`default_nettype wire

// File: rtl/sram_1r1w_core.sv
// ============================================================================
//  Module      : sram_1r1w_core
//  Description : Inferred block-RAM, lane write enables, registered read, no reset.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_1r1w_core #(
    parameter int LW  = 257,
    parameter int NL  = 1,
    parameter int DEP = 1024,
    parameter int AW  = 10
) (
    input  wire logic           clk,
    input  wire logic [NL-1:0]  we,
    input  wire logic [AW-1:0]  wadr,
    input  wire logic [NL*LW-1:0] wdat,
    input  wire logic           re,
    input  wire logic [AW-1:0]  radr,
    output logic [NL*LW-1:0]    rdat
);
    logic [NL*LW-1:0] r_mem [DEP];

    always_ff @(posedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (we[k]) r_mem[wadr][k*LW +: LW] <= wdat[k*LW +: LW];
        end
        if (re) rdat <= r_mem[radr];
    end
endmodule

`default_nettype wire

// File: rtl/sram_1r1w_bwe_clr.sv
// ============================================================================
//  Module      : sram_1r1w_bwe_clr
//  Description : 1R1W SRAM with lane write enables, self-clearing init,
//                write-to-read forwarding, READ_LAT 1/2. Option: SRAM_PARITY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_1r1w_bwe_clr
    import rfPhoenixPkg::*;
#(
    parameter int WID      = 257,
    parameter int DEP      = 1024,
    parameter int BWID     = 257,
    parameter int READ_LAT = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sram_1r1w_bwe_clr_if.slave bus
);
    localparam int c_aw = (DEP > 1) ? $clog2(DEP) : 1;
    localparam int c_nb = WID / BWID;
`ifdef SRAM_PARITY_EN
    localparam int c_pb = 1;
`else
    localparam int c_pb = 0;
`endif
    localparam int c_lw   = BWID + c_pb;
    localparam bit c_pow2 = (DEP == (1 << c_aw));

    if (WID % BWID != 0) begin : g_bad_bwid
        $error("sram_1r1w_bwe_clr: WID must be a multiple of BWID");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("sram_1r1w_bwe_clr: READ_LAT must be 1 or 2");
    end
    if (WID > SRAM_MAX_WID) begin : g_bad_wid
        $error("sram_1r1w_bwe_clr: WID exceeds SRAM_MAX_WID");
    end

    sram_init_state_t       r_state, w_state_nxt;
    logic [c_aw-1:0]        r_cnt;
    logic                   w_run, w_wok, w_rok, w_rd_acc, w_hit;
    logic [c_nb-1:0]        w_core_we;
    logic [c_aw-1:0]        w_core_wadr;
    logic [c_nb*c_lw-1:0]   w_core_wdat, w_user_wdat, w_core_rdat;
    logic [WID-1:0]         w_rd_data, w_m1;
    logic [c_nb-1:0]        r_fwd_en;
    logic [WID-1:0]         r_fwd_dat;
    logic                   r_rok, r_v1, w_perr1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SRAM_CLR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == SRAM_CLR) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SRAM_CLR: if (r_cnt == c_aw'(DEP - 1)) w_state_nxt = SRAM_RUN;
            SRAM_RUN: w_state_nxt = SRAM_RUN;
            default:  w_state_nxt = SRAM_CLR;
        endcase
    end

    assign w_run    = (r_state == SRAM_RUN);
    assign bus.rdy  = w_run;
    assign w_wok    = c_pow2 || (int'(bus.wadr) < DEP);
    assign w_rok    = c_pow2 || (int'(bus.radr) < DEP);
    assign w_rd_acc = w_run && bus.rd;
    assign w_hit    = bus.wr && bus.rd && (bus.wadr == bus.radr) && w_wok;

    // Clear writes all-zero lanes; zero data has zero even parity, so no parity fixup needed.
    always_comb begin
        w_core_we   = '0;
        w_core_wadr = r_cnt;
        w_core_wdat = '0;
        if (!w_run) begin
            w_core_we = '1;
        end else if (bus.wr && w_wok) begin
            w_core_we   = bus.wsel;
            w_core_wadr = bus.wadr;
            w_core_wdat = w_user_wdat;
        end
    end

    sram_1r1w_core #(
        .LW  (c_lw),
        .NL  (c_nb),
        .DEP (DEP),
        .AW  (c_aw)
    ) u_core (
        .clk  (clk),
        .we   (w_core_we),
        .wadr (w_core_wadr),
        .wdat (w_core_wdat),
        .re   (w_rd_acc && w_rok),
        .radr (bus.radr),
        .rdat (w_core_rdat)
    );

    // Forward lanes and range flag only change on an accepted read, so o holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_rok     <= 1'b0;
            r_fwd_en  <= '0;
            r_fwd_dat <= '0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_rok     <= w_rok;
                r_fwd_en  <= w_hit ? bus.wsel : '0;
                r_fwd_dat <= bus.i;
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic [c_nb-1:0] w_wpar, w_spar, w_rpar;
    assign w_wpar  = c_nb'(lane_parity(SRAM_MAX_WID'(bus.i), WID, BWID)) ^ c_nb'(bus.perr_inj);
    assign w_rpar  = c_nb'(lane_parity(SRAM_MAX_WID'(w_rd_data), WID, BWID));
    assign w_perr1 = r_v1 && r_rok && (|((w_rpar ^ w_spar) & ~r_fwd_en));
`else
    logic w_unused_inj;
    assign w_unused_inj = bus.perr_inj;
    assign w_perr1      = 1'b0;
`endif

    for (genvar k = 0; k < c_nb; k++) begin : g_lane
`ifdef SRAM_PARITY_EN
        assign w_user_wdat[k*c_lw +: c_lw] = {w_wpar[k], bus.i[k*BWID +: BWID]};
        assign w_spar[k]                   = w_core_rdat[k*c_lw + BWID];
`else
        assign w_user_wdat[k*c_lw +: c_lw] = bus.i[k*BWID +: BWID];
`endif
        assign w_rd_data[k*BWID +: BWID] = w_core_rdat[k*c_lw +: BWID];
        assign w_m1[k*BWID +: BWID] = !r_rok      ? '0 :
                                      r_fwd_en[k] ? r_fwd_dat[k*BWID +: BWID] :
                                                    w_rd_data[k*BWID +: BWID];
    end

    if (READ_LAT == 2) begin : g_lat2
        logic [WID-1:0] r_o2;
        logic           r_ov2, r_perr2;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_o2    <= '0;
                r_ov2   <= 1'b0;
                r_perr2 <= 1'b0;
            end else begin
                r_ov2   <= r_v1;
                r_perr2 <= w_perr1;
                if (r_v1) r_o2 <= w_m1;
            end
        end
        assign bus.o    = r_o2;
        assign bus.ov   = r_ov2;
        assign bus.perr = r_perr2;
    end else begin : g_lat1
        assign bus.o    = w_m1;
        assign bus.ov   = r_v1;
        assign bus.perr = w_perr1;
    end
endmodule

`default_nettype wire
